// File: rtl/iohub_tx_arbiter.sv
// rtl/iohub_tx_arbiter.sv - round-robin arbiter framing two 16-bit sources onto one UART as tag/hi/lo bytes
// tx_done_i is only honoured in *_WAIT states so early or spurious pulses never advance a frame.
module iohub_tx_arbiter #(
  parameter logic [7:0] TAG_BASE = 8'hA0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic [15:0] req0_data_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [15:0] req1_data_i,
  output logic        req1_ready_o,
  output logic [7:0]  tx_byte_o,
  output logic        tx_start_o,
  input  logic        tx_done_i,
  output logic        busy_o,
  output logic        grant_o,
  output logic [15:0] words_sent_o
);

  typedef enum logic [2:0] {
    IDLE, TAG_ISS, TAG_WAIT, HI_ISS, HI_WAIT, LO_ISS, LO_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [15:0] words_sent_q, words_sent_d;
  logic        win1;
  logic        accept;

  // On a tie the source that did not win last time goes next.
  assign win1   = req1_valid_i & (~req0_valid_i | ~last_grant_q);
  assign accept = (state_q == IDLE) & (req0_valid_i | req1_valid_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      word_q       <= 16'h0000;
      tx_byte_q    <= 8'h00;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      words_sent_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      tx_byte_q    <= tx_byte_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      words_sent_q <= words_sent_d;
    end
  end

  // The byte for each phase is loaded on entry to its ISS state so it is stable under tx_start_o.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    tx_byte_d    = tx_byte_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    words_sent_d = words_sent_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = TAG_ISS;
          word_d       = win1 ? req1_data_i : req0_data_i;
          last_grant_d = win1;
          grant_d      = win1;
          tx_byte_d    = TAG_BASE | {7'b0, win1};
        end
      end
      TAG_ISS: state_d = TAG_WAIT;
      TAG_WAIT: begin
        if (tx_done_i) begin
          state_d   = HI_ISS;
          tx_byte_d = word_q[15:8];
        end
      end
      HI_ISS: state_d = HI_WAIT;
      HI_WAIT: begin
        if (tx_done_i) begin
          state_d   = LO_ISS;
          tx_byte_d = word_q[7:0];
        end
      end
      LO_ISS: state_d = LO_WAIT;
      LO_WAIT: begin
        if (tx_done_i) begin
          state_d      = IDLE;
          words_sent_d = words_sent_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = accept & ~win1;
    req1_ready_o = accept & win1;
    tx_start_o   = (state_q == TAG_ISS) | (state_q == HI_ISS) | (state_q == LO_ISS);
    busy_o       = (state_q != IDLE);
    grant_o      = grant_q;
    tx_byte_o    = tx_byte_q;
    words_sent_o = words_sent_q;
  end

endmodule

// File: tb/tb_iohub_tx_arbiter.sv
// tb/tb_iohub_tx_arbiter.sv - directed self-checking bench for iohub_tx_arbiter
module tb_iohub_tx_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i;
  logic [15:0] req0_data_i;
  logic        req0_ready_o;
  logic        req1_valid_i;
  logic [15:0] req1_data_i;
  logic        req1_ready_o;
  logic [7:0]  tx_byte_o;
  logic        tx_start_o;
  logic        tx_done_i;
  logic        busy_o;
  logic        grant_o;
  logic [15:0] words_sent_o;

  int n_checks = 0;
  int n_fails  = 0;
  int start_cnt = 0;
  int ready_cnt = 0;

  iohub_tx_arbiter #(.TAG_BASE(8'hA0)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .tx_byte_o    (tx_byte_o),
    .tx_start_o   (tx_start_o),
    .tx_done_i    (tx_done_i),
    .busy_o       (busy_o),
    .grant_o      (grant_o),
    .words_sent_o (words_sent_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (tx_start_o) start_cnt++;
    if (req0_ready_o || req1_ready_o) ready_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for a start pulse, checks the byte, then answers with tx_done_i dly cycles later.
  task automatic xfer_byte(input string tag, input logic [7:0] exp, input int dly, input bit early);
    int n;
    n = 0;
    while (!tx_start_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check_eq({tag, " start"}, tx_start_o, 1);
    check_eq({tag, " byte"}, tx_byte_o, exp);
    if (early) tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check_eq({tag, " start one cycle"}, tx_start_o, 0);
    repeat (dly - 1) @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] t, input logic [7:0] h,
                          input logic [7:0] l, input int dly, input bit early);
    int s0;
    s0 = start_cnt;
    xfer_byte({tag, " tag"}, t, dly, early);
    xfer_byte({tag, " hi"}, h, dly, early);
    xfer_byte({tag, " lo"}, l, dly, early);
    check_eq({tag, " starts"}, start_cnt - s0, 3);
    check_eq({tag, " idle after"}, busy_o, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    int s0;
    int r0;
    rst_i = 1'b1;
    req0_valid_i = 1'b0;
    req0_data_i  = 16'h0000;
    req1_valid_i = 1'b0;
    req1_data_i  = 16'h0000;
    tx_done_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst tx_byte", tx_byte_o, 8'h00);
    check_eq("rst tx_start", tx_start_o, 0);
    check_eq("rst busy", busy_o, 0);
    check_eq("rst grant", grant_o, 0);
    check_eq("rst words", words_sent_o, 0);
    check_eq("rst ready0", req0_ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // single word from source 0
    r0 = ready_cnt;
    req0_data_i  = 16'h1234;
    req0_valid_i = 1'b1;
    #1;
    check_eq("single ready0", req0_ready_o, 1);
    check_eq("single ready1", req1_ready_o, 0);
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    check_eq("single ready pulses", ready_cnt - r0, 1);
    check_eq("single busy", busy_o, 1);
    do_frame("single", 8'hA0, 8'h12, 8'h34, 10, 1'b0);
    check_eq("single words", words_sent_o, 16'd1);
    check_eq("single grant", grant_o, 0);

    // tie after reset: source 0 first, then strict alternation
    do_reset();
    req0_data_i  = 16'hAAAA;
    req1_data_i  = 16'h5555;
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    #1;
    check_eq("tie first ready0", req0_ready_o, 1);
    for (int f = 0; f < 4; f++) begin
      if (f % 2 == 0) do_frame("tie0", 8'hA0, 8'hAA, 8'hAA, 2, 1'b0);
      else            do_frame("tie1", 8'hA1, 8'h55, 8'h55, 2, 1'b0);
      check_eq("tie grant", grant_o, f % 2);
      if (f < 3) check_eq("tie next ready1", req1_ready_o, (f % 2 == 0) ? 1 : 0);
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    check_eq("tie words", words_sent_o, 16'd4);

    // early/spurious done pulses
    s0 = start_cnt;
    tx_done_i = 1'b1;
    repeat (2) @(negedge clk_i);
    tx_done_i = 1'b0;
    check_eq("early idle busy", busy_o, 0);
    check_eq("early idle starts", start_cnt - s0, 0);
    req0_data_i  = 16'hC33C;
    req0_valid_i = 1'b1;
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    do_frame("early", 8'hA0, 8'hC3, 8'h3C, 4, 1'b1);
    check_eq("early words", words_sent_o, 16'd5);

    // source data changes after accept
    req1_data_i  = 16'hBEEF;
    req1_valid_i = 1'b1;
    #1;
    check_eq("chg ready1", req1_ready_o, 1);
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    req1_data_i  = 16'h0000;
    do_frame("chg", 8'hA1, 8'hBE, 8'hEF, 3, 1'b0);
    check_eq("chg grant", grant_o, 1);
    check_eq("chg words", words_sent_o, 16'd6);

    // reset during HI_WAIT
    req0_data_i  = 16'h1357;
    req0_valid_i = 1'b1;
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    xfer_byte("mid tag", 8'hA0, 2, 1'b0);
    @(negedge clk_i);
    check_eq("mid in wait", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check_eq("mid rst busy", busy_o, 0);
    check_eq("mid rst start", tx_start_o, 0);
    check_eq("mid rst byte", tx_byte_o, 8'h00);
    check_eq("mid rst grant", grant_o, 0);
    check_eq("mid rst words", words_sent_o, 16'd0);
    @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    rst_i = 1'b0;
    s0 = start_cnt;
    repeat (5) @(negedge clk_i);
    check_eq("mid no starts", start_cnt - s0, 0);
    req0_valid_i = 1'b1;
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    do_frame("mid after", 8'hA0, 8'h13, 8'h57, 2, 1'b0);
    check_eq("mid after words", words_sent_o, 16'd1);

    // counter wrap from a preloaded 16'hFFFF
    force dut.words_sent_q = 16'hFFFF;
    @(negedge clk_i);
    release dut.words_sent_q;
    @(negedge clk_i);
    check_eq("wrap preload", words_sent_o, 16'hFFFF);
    req1_data_i  = 16'h0F0F;
    req1_valid_i = 1'b1;
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    do_frame("wrap", 8'hA1, 8'h0F, 8'h0F, 2, 1'b0);
    check_eq("wrap words", words_sent_o, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/iohub_tx_arbiter.md
# iohub_tx_arbiter

Shares the single iohub UART transmitter between two 16-bit word sources, e.g. the CPU result path and the debug/trace path, for Atlus-to-PC traffic. Grants one source at a time with round-robin fairness and captures its word. Sends the word as a three-byte frame: source tag, high byte, low byte. Paces each byte on the UART's done pulse, so the byte stream the PC sees is never interleaved between sources.

## Interface
Parameters:
- TAG_BASE, 8'hA0, tag byte for source 0; source 1 uses TAG_BASE | 8'h01.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req0_valid_i  input  1  source 0 has a word.
- req0_data_i  input  16  source 0 word.
- req0_ready_o  output  1  source 0 word accepted this cycle.
- req1_valid_i  input  1  source 1 has a word.
- req1_data_i  input  16  source 1 word.
- req1_ready_o  output  1  source 1 word accepted this cycle.
- tx_byte_o  output  8  byte to UART transmitter.
- tx_start_o  output  1  one-cycle pulse: UART loads tx_byte_o.
- tx_done_i  input  1  one-cycle pulse from UART: current byte fully shifted out.
- busy_o  output  1  frame in progress (state != IDLE).
- grant_o  output  1  source of the current or last frame.
- words_sent_o  output  16  completed-frame counter, wraps 16'hFFFF -> 0.

## Operation
- State machine: IDLE, TAG_ISS, TAG_WAIT, HI_ISS, HI_WAIT, LO_ISS, LO_WAIT.
- IDLE: arbitration is combinational on the valid inputs.
  - Only one valid: that source wins.
  - Both valid: the source not equal to the last_grant register wins.
  - last_grant resets to 1, so source 0 wins the first tie.
- Winner's reqN_ready_o is asserted in the same cycle it wins; ready is only ever asserted in IDLE.
- On accept:
  - Data is captured into a 16-bit word register.
  - last_grant and grant_o are set to the winner.
  - The FSM moves to TAG_ISS.
- Each *_ISS state:
  - tx_start_o = 1 for exactly that cycle; tx_byte_o is loaded with the byte for the phase.
  - Bytes: TAG_ISS sends tag, HI_ISS sends word[15:8], LO_ISS sends word[7:0].
  - Next state is the matching *_WAIT, unconditionally.
- *_WAIT: holds until tx_done_i = 1, then goes to the next *_ISS.
  - LO_WAIT goes to IDLE instead, and words_sent_o increments.
- tx_done_i is ignored in IDLE and in every *_ISS state; a spurious or early pulse has no effect.
- tx_byte_o holds its value from ISS until the next ISS load; it is not cleared in IDLE.
- Source data may change after accept without affecting the frame in flight.

## Timing
- Reset values:
  - Outputs: tx_byte_o = 8'h00, tx_start_o = 0, req0/1_ready_o = 0, busy_o = 0, grant_o = 0, words_sent_o = 0.
  - Internal: state = IDLE, last_grant = 1.
- Frame sequence, with accept in cycle N:
  - Tag tx_start_o in N+1.
  - tx_done_i in cycle M gives the next byte's tx_start_o in M+1.
  - Final tx_done_i in cycle L: IDLE in L+1, words_sent_o updated in L+1.
- Back-to-back: a new accept may occur in L+1, with its tag start in L+2. Minimum gap between frames is one idle cycle.
- tx_done_i in the same cycle as tx_start_o is ignored, because the FSM is in ISS.
- busy_o is high from N+1 through L inclusive.
- Reset mid-frame:
  - Immediate return to IDLE and all outputs to reset values.
  - The partial frame is abandoned and not counted.
  - No further tx_start_o until a new accept.

## Test plan
- Single word: req0 valid with 16'h1234, done pulses 10 cycles after each start -> bytes A0, 12, 34 with exactly three start pulses. req0_ready_o high for one cycle; words_sent_o = 1; grant_o = 0.
- Tie after reset: req0 = 16'hAAAA and req1 = 16'h5555 held valid -> frame A0 AA AA, then A1 55 55. Both sources held valid -> strict alternation continues for 4 frames.
- Early done: tx_done_i pulsed in IDLE and in the same cycle as every tx_start_o -> ignored, no state advance; the frame completes only on real done pulses.
- Source change: req1 accepted with 16'hBEEF, data driven to 16'h0000 the next cycle -> bytes A1, BE, EF.
- Reset mid-frame: assert rst_i during HI_WAIT -> all outputs at reset values and words_sent_o = 0. The next request's first byte is a tag.
- Counter wrap: force 65536 frames, or preload words_sent_o to 16'hFFFF in the bench -> next frame yields 16'h0000.
